// File: rtl/demux_rr_sched.sv
// rtl/demux_rr_sched.sv - one-word demux scheduler with round-robin target and stall re-route
module demux_rr_sched #(
   parameter int WIDTH = 8,
   parameter int SNUM  = 4,
   parameter int TMO   = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   in_ready,
   input  logic [(1<<SNUM)-1:0]   ch_en,
   input  logic [(1<<SNUM)-1:0]   out_ready,
   output logic [(1<<SNUM)-1:0]   out_valid,
   output logic [WIDTH-1:0]       out_data,
   output logic [SNUM-1:0]        sel,
   output logic                   busy,
   output logic [15:0]            xfer_cnt
);

   localparam int         N     = 1 << SNUM;
   localparam logic [7:0] TMO_V = 8'(TMO);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state_q, state_nxt;
   logic [WIDTH-1:0] data_q, data_nxt;
   logic [SNUM-1:0]  sel_q, sel_nxt;
   logic [SNUM-1:0]  ptr_q, ptr_nxt;
   logic [7:0]       timer_q, timer_nxt;
   logic [15:0]      cnt_q, cnt_nxt;
   logic             accept;

   // First enabled channel at or after start, wrapping; dflt when nothing is enabled.
   function automatic logic [SNUM-1:0] scan(input logic [N-1:0]    en,
                                            input logic [SNUM-1:0] start,
                                            input logic [SNUM-1:0] dflt);
      logic [SNUM-1:0] idx;
      logic [SNUM-1:0] res;
      logic            found;
      res   = dflt;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx = start + SNUM'(i);
         if (!found && en[idx]) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   // Handshake and status outputs derived from the held state.
   always_comb begin
      in_ready  = (state_q == IDLE) && (|ch_en);
      busy      = (state_q == SEND);
      accept    = in_valid && in_ready;
      out_valid = '0;
      if (state_q == SEND && ch_en[sel_q]) begin
         out_valid[sel_q] = 1'b1;
      end
   end

   assign out_data = data_q;
   assign sel      = sel_q;
   assign xfer_cnt = cnt_q;

   // Next-state: capture, deliver, or re-route a disabled or stalled target.
   always_comb begin
      state_nxt = state_q;
      data_nxt  = data_q;
      sel_nxt   = sel_q;
      ptr_nxt   = ptr_q;
      timer_nxt = timer_q;
      cnt_nxt   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_nxt = SEND;
               data_nxt  = in_data;
               sel_nxt   = scan(ch_en, ptr_q, ptr_q);
               timer_nxt = 8'd0;
            end
         end
         SEND: begin
            if (~|ch_en) begin
               // nowhere to go: park the word until some channel comes back
               state_nxt = SEND;
            end else if (!ch_en[sel_q]) begin
               sel_nxt   = scan(ch_en, sel_q + SNUM'(1), sel_q);
               timer_nxt = 8'd0;
            end else if (out_ready[sel_q]) begin
               state_nxt = IDLE;
               ptr_nxt   = sel_q + SNUM'(1);
               cnt_nxt   = cnt_q + 16'd1;
            end else if (timer_q == TMO_V) begin
               // scan wraps back to sel_q when it is the only enabled channel
               sel_nxt   = scan(ch_en, sel_q + SNUM'(1), sel_q);
               timer_nxt = 8'd0;
            end else begin
               timer_nxt = timer_q + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register with asynchronous reset that discards any held word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         timer_q <= 8'd0;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_nxt;
         data_q  <= data_nxt;
         sel_q   <= sel_nxt;
         ptr_q   <= ptr_nxt;
         timer_q <= timer_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_demux_rr_sched.sv
// tb/tb_demux_rr_sched.sv - vector, corner-case and randomized model bench for demux_rr_sched
module tb_demux_rr_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic [15:0] ch_en = 16'h0000;
   logic [15:0] out_ready = 16'h0000;
   logic [15:0] out_valid;
   logic [7:0]  out_data;
   logic [3:0]  sel;
   logic        busy;
   logic [15:0] xfer_cnt;

   int errors = 0;
   int checks = 0;

   demux_rr_sched #(.WIDTH(8), .SNUM(4), .TMO(15)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .ch_en(ch_en), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .sel(sel), .busy(busy), .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference model: one held word, a wait counter and a round-robin pointer
   bit          m_busy;
   int          m_word, m_sel, m_ptr, m_timer, m_cnt;

   function automatic int first_en(input logic [15:0] en, input int start);
      for (int i = 0; i < 16; i++) begin
         if (en[(start + i) % 16]) return (start + i) % 16;
      end
      return start % 16;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_word = 0; m_sel = 0; m_ptr = 0; m_timer = 0; m_cnt = 0;
   endtask

   task automatic model_step(input logic iv, input logic [7:0] d,
                             input logic [15:0] en, input logic [15:0] rdy);
      if (m_busy) begin
         if (en != 16'h0) begin
            if (!en[m_sel]) begin
               m_sel = first_en(en, m_sel + 1); m_timer = 0;
            end else if (rdy[m_sel]) begin
               m_busy = 0; m_ptr = (m_sel + 1) % 16; m_cnt = (m_cnt + 1) % 65536;
            end else if (m_timer == 15) begin
               m_sel = first_en(en, m_sel + 1); m_timer = 0;
            end else begin
               m_timer = m_timer + 1;
            end
         end
      end else if (iv && en != 16'h0) begin
         m_busy = 1; m_word = int'(d); m_sel = first_en(en, m_ptr); m_timer = 0;
      end
   endtask

   typedef struct {
      logic [15:0] en;
      logic [7:0]  data;
      int          exp_sel;
      int          exp_cnt;
   } vec_t;

   vec_t tbl[20];

   initial begin
      logic [15:0] pv;
      int tmo_ok;

      for (int i = 0; i < 17; i++) begin
         tbl[i].en = 16'hFFFF; tbl[i].data = 8'(i); tbl[i].exp_sel = i % 16; tbl[i].exp_cnt = i + 1;
      end
      tbl[17] = '{16'h0024, 8'h91, 2, 18};
      tbl[18] = '{16'h0024, 8'h92, 5, 19};
      tbl[19] = '{16'h0024, 8'h93, 2, 20};

      // reset state
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
      do_reset();

      // table: full-enable sweep then sparse mask
      for (int i = 0; i < 20; i++) begin
         ch_en = tbl[i].en; out_ready = 16'hFFFF; in_valid = 1'b1; in_data = tbl[i].data;
         #1;
         chk("tbl_in_ready", 32'(in_ready), 32'h1);
         tick();
         in_valid = 1'b0;
         chk("tbl_busy", 32'(busy), 32'h1);
         chk("tbl_sel", 32'(sel), 32'(tbl[i].exp_sel));
         chk("tbl_out_valid", 32'(out_valid), 32'(16'h1 << tbl[i].exp_sel));
         chk("tbl_out_data", 32'(out_data), 32'(tbl[i].data));
         tick();
         chk("tbl_idle", 32'(busy), 32'h0);
         chk("tbl_xfer_cnt", 32'(xfer_cnt), 32'(tbl[i].exp_cnt));
      end

      // stall timeout re-route
      do_reset();
      ch_en = 16'h0009; out_ready = 16'h0000; in_valid = 1'b1; in_data = 8'hA5;
      tick();
      in_valid = 1'b0;
      tmo_ok = 0;
      for (int k = 0; k < 16; k++) begin
         if (out_valid == 16'h0001) tmo_ok++;
         if (k != 15) tick();
      end
      chk("tmo_valid_cycles", 32'(tmo_ok), 32'd16);
      tick();
      chk("tmo_sel", 32'(sel), 32'd3);
      chk("tmo_out_valid", 32'(out_valid), 32'h0008);
      chk("tmo_out_data", 32'(out_data), 32'hA5);
      out_ready = 16'h0008;
      tick();
      chk("tmo_xfer", 32'(xfer_cnt), 32'd1);
      chk("tmo_idle", 32'(busy), 32'h0);
      ch_en = 16'h0019; out_ready = 16'hFFFF; in_valid = 1'b1; in_data = 8'h5A;
      tick();
      in_valid = 1'b0;
      chk("tmo_next_ptr", 32'(sel), 32'd4);
      tick();

      // no enabled channel blocks acceptance
      do_reset();
      ch_en = 16'h0000; out_ready = 16'hFFFF; in_valid = 1'b1; in_data = 8'h77;
      #1;
      chk("noen_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("noen_no_capture", 32'(busy), 32'h0);
      ch_en = 16'h8000;
      #1;
      chk("ch15_in_ready", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
      chk("ch15_sel", 32'(sel), 32'd15);
      chk("ch15_out_valid", 32'(out_valid), 32'h8000);
      tick();
      ch_en = 16'hFFFF; in_valid = 1'b1; in_data = 8'h11;
      tick();
      in_valid = 1'b0;
      chk("ch15_ptr_wrap", 32'(sel), 32'd0);
      tick();

      // disable selected channel in the same cycle it becomes ready
      do_reset();
      ch_en = 16'h0030; out_ready = 16'h0000; in_valid = 1'b1; in_data = 8'h44;
      tick();
      in_valid = 1'b0;
      chk("dis_sel4", 32'(sel), 32'd4);
      ch_en = 16'h0020; out_ready = 16'h0010;
      #1;
      chk("dis_out_valid", 32'(out_valid), 32'h0);
      tick();
      chk("dis_reroute", 32'(sel), 32'd5);
      chk("dis_busy", 32'(busy), 32'h1);
      chk("dis_no_xfer", 32'(xfer_cnt), 32'd0);
      out_ready = 16'h0020;
      tick();
      chk("dis_xfer", 32'(xfer_cnt), 32'd1);

      // all channels disabled while holding a word
      do_reset();
      ch_en = 16'h0002; out_ready = 16'h0000; in_valid = 1'b1; in_data = 8'h66;
      tick();
      in_valid = 1'b0;
      ch_en = 16'h0000;
      for (int k = 0; k < 3; k++) tick();
      chk("park_out_valid", 32'(out_valid), 32'h0);
      chk("park_busy", 32'(busy), 32'h1);
      chk("park_sel", 32'(sel), 32'd1);
      chk("park_data", 32'(out_data), 32'h66);
      ch_en = 16'h0002; out_ready = 16'h0002;
      #1;
      chk("park_resume", 32'(out_valid), 32'h0002);
      tick();
      chk("park_xfer", 32'(xfer_cnt), 32'd1);

      // reset while holding a word
      do_reset();
      ch_en = 16'hFFFF; out_ready = 16'hFFFF; in_valid = 1'b1; in_data = 8'h01;
      tick();
      in_valid = 1'b0;
      tick();
      chk("rmid_pre_cnt", 32'(xfer_cnt), 32'd1);
      out_ready = 16'h0000; in_valid = 1'b1; in_data = 8'h3C;
      tick();
      in_valid = 1'b0;
      chk("rmid_held", 32'(out_data), 32'h3C);
      rst = 1'b1;
      #1;
      chk("rmid_out_valid", 32'(out_valid), 32'h0);
      chk("rmid_busy", 32'(busy), 32'h0);
      chk("rmid_out_data", 32'(out_data), 32'h0);
      chk("rmid_xfer_cnt", 32'(xfer_cnt), 32'h0);
      tick();
      rst = 1'b0;
      chk("rmid_after_edge", 32'(busy), 32'h0);

      // randomized traffic against the model
      do_reset();
      model_reset();
      ch_en = 16'hFFFF; out_ready = 16'hFFFF;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 4))
               0: ch_en = 16'($urandom);
               1: ch_en = 16'h1 << $urandom_range(0, 15);
               2: ch_en = 16'hFFFF;
               3: ch_en = 16'($urandom) & 16'($urandom);
               default: ch_en = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            endcase
         end
         if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 3))
               0: out_ready = 16'h0000;
               1: out_ready = 16'($urandom);
               2: out_ready = 16'hFFFF;
               default: out_ready = 16'h1 << $urandom_range(0, 15);
            endcase
         end
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 8'($urandom);
         #1;
         pv = (m_busy && ch_en[m_sel]) ? (16'h1 << m_sel) : 16'h0;
         chk("rnd_in_ready", 32'(in_ready), 32'(!m_busy && ch_en != 16'h0));
         chk("rnd_out_valid", 32'(out_valid), 32'(pv));
         chk("rnd_out_data", 32'(out_data), 32'(m_word));
         chk("rnd_sel", 32'(sel), 32'(m_sel));
         chk("rnd_busy", 32'(busy), 32'(m_busy));
         chk("rnd_xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
         @(posedge clk);
         model_step(in_valid, in_data, ch_en, out_ready);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
